// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its decoder neighbour.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned PC_STEP     = 4;

    // addi x0,x0,0: the only safe bubble, since the decoder's default decode writes a register
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or replace it with a NOP bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  bubble_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH-1:0] pc_plus4_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic                  valid_q, valid_d;

    // Bubble wins over load; the pc fields of a bubble are left as they were
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (bubble_i) begin
            instr_d = DATA_WIDTH'(NOP_INSTR);
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q    <= DATA_WIDTH'(NOP_INSTR);
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, one-entry skid buffer and IF/ID register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  imem_valid_i,
    output logic [DATA_WIDTH-1:0] instr_d_o,
    output logic [ADDR_WIDTH-1:0] pc_d_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_d_o,
    output logic                  valid_d_o
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [ADDR_WIDTH-1:0] skid_pc4_q, skid_pc4_d;
    logic                  req_q, req_d;

    logic                  hs;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  ifid_load;
    logic                  ifid_bubble;
    logic [DATA_WIDTH-1:0] ifid_instr;
    logic [ADDR_WIDTH-1:0] ifid_pc;
    logic [ADDR_WIDTH-1:0] ifid_pc4;

    assign hs       = req_q & imem_valid_i;
    assign pc_plus4 = pc_q + ADDR_WIDTH'(PC_STEP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            skid_instr_q <= DATA_WIDTH'(NOP_INSTR);
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            req_q        <= req_d;
        end
    end

    // Next state; only an outstanding request that gets flushed needs DISCARD
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (flush_i) begin
                    state_d = (req_q && !imem_valid_i) ? DISCARD : FETCH;
                end else if (hs && stall_i) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (flush_i || !stall_i) begin
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (hs) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Datapath controls: PC, redirect target, skid buffer and IF/ID load/bubble
    always_comb begin
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_instr   = imem_rdata_i;
        ifid_pc      = pc_q;
        ifid_pc4     = pc_plus4;
        req_d        = (state_d != FULL);
        case (state_q)
            FETCH: begin
                if (flush_i) begin
                    ifid_bubble = 1'b1;
                    if (req_q && !imem_valid_i) begin
                        tgt_d = redirect_pc_i;
                    end else begin
                        pc_d = redirect_pc_i;
                    end
                end else if (hs) begin
                    pc_d = pc_plus4;
                    if (stall_i) begin
                        skid_instr_d = imem_rdata_i;
                        skid_pc_d    = pc_q;
                        skid_pc4_d   = pc_plus4;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end
            end
            FULL: begin
                ifid_instr = skid_instr_q;
                ifid_pc    = skid_pc_q;
                ifid_pc4   = skid_pc4_q;
                if (flush_i) begin
                    ifid_bubble = 1'b1;
                    pc_d        = redirect_pc_i;
                end else if (!stall_i) begin
                    ifid_load = 1'b1;
                end
            end
            DISCARD: begin
                if (flush_i) begin
                    ifid_bubble = 1'b1;
                    if (hs) begin
                        pc_d = redirect_pc_i;
                    end else begin
                        tgt_d = redirect_pc_i;
                    end
                end else if (hs) begin
                    pc_d = tgt_q;
                end
            end
            default: ;
        endcase
    end

    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_id (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .instr_i    (ifid_instr),
        .pc_i       (ifid_pc),
        .pc_plus4_i (ifid_pc4),
        .instr_o    (instr_d_o),
        .pc_o       (pc_d_o),
        .pc_plus4_o (pc_plus4_d_o),
        .valid_o    (valid_d_o)
    );

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, multi-cycle corner sequences and a randomized queue-based model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [31:0] redir;
    logic        imem_req, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr_d, pc_d, pc4_d;
    logic        valid_d;

    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    int rand_wait = 0;
    int cnt = 0;
    bit mem_rand = 1'b0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_pc_i (redir),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .imem_valid_i  (imem_valid),
        .instr_d_o     (instr_d),
        .pc_d_o        (pc_d),
        .pc_plus4_d_o  (pc4_d),
        .valid_d_o     (valid_d)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    // Memory: answers after cnt wait cycles of a pending request (0 waits = same-cycle response)
    assign imem_rdata = mem_word(imem_addr);
    assign imem_valid = imem_req && (cnt >= (mem_rand ? rand_wait : mem_wait));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 0;
        end else if (imem_req && imem_valid) begin
            cnt       <= 0;
            rand_wait <= int'($urandom_range(0, 3));
        end else if (imem_req) begin
            cnt <= cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        redir = '0;
        repeat (2) @(negedge clk);
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr,     32'd0);
        check("rst_instr", instr_d,       NOP);
        check("rst_pc",    pc_d,          32'd0);
        check("rst_pc4",   pc4_d,         32'd0);
        check("rst_valid", 32'(valid_d),  32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_addr(input logic [31:0] a, input int max);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_addr_timeout", 32'(n < max), 32'd1);
    endtask

    task automatic wait_valid_d(input int max);
        int n = 0;
        while (!valid_d && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid_timeout", 32'(n < max), 32'd1);
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] redir;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic        nop;
    } vec_t;

    vec_t tbl [19];

    // Random-phase model: fetched-but-undelivered pcs, and the program-order next fetch
    logic [31:0] pend_q [$];
    logic [31:0] m_instr, m_pc, m_pc4, exp_fetch, prev_addr, p;
    logic        m_v, drop_next, first, prev_wait, hs;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait memory: streaming, stall into skid, flush with handshake, pc wrap, flush in FULL
        tbl[0]  = '{0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        1};
        tbl[1]  = '{0, 0, 32'h0,        1, 32'h4,        1, 32'h0,        0};
        tbl[2]  = '{1, 0, 32'h0,        1, 32'h8,        1, 32'h4,        0};
        tbl[3]  = '{1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        0};
        tbl[4]  = '{1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        0};
        tbl[5]  = '{1, 0, 32'h0,        0, 32'hC,        1, 32'h4,        0};
        tbl[6]  = '{0, 0, 32'h0,        0, 32'hC,        1, 32'h4,        0};
        tbl[7]  = '{0, 1, 32'h100,      1, 32'hC,        1, 32'h8,        0};
        tbl[8]  = '{0, 0, 32'h0,        1, 32'h100,      0, 32'h0,        1};
        tbl[9]  = '{0, 0, 32'h0,        1, 32'h104,      1, 32'h100,      0};
        tbl[10] = '{0, 1, 32'hFFFFFFF8, 1, 32'h108,      1, 32'h104,      0};
        tbl[11] = '{0, 0, 32'h0,        1, 32'hFFFFFFF8, 0, 32'h0,        1};
        tbl[12] = '{0, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 32'hFFFFFFF8, 0};
        tbl[13] = '{0, 0, 32'h0,        1, 32'h0,        1, 32'hFFFFFFFC, 0};
        tbl[14] = '{1, 1, 32'h40,       1, 32'h4,        1, 32'h0,        0};
        tbl[15] = '{1, 0, 32'h0,        1, 32'h40,       0, 32'h0,        1};
        tbl[16] = '{0, 1, 32'h80,       0, 32'h44,       0, 32'h0,        1};
        tbl[17] = '{0, 0, 32'h0,        1, 32'h80,       0, 32'h0,        1};
        tbl[18] = '{0, 0, 32'h0,        1, 32'h84,       1, 32'h80,       0};

        mem_rand = 1'b0;
        mem_wait = 0;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            check($sformatf("t%0d_req", i),   32'(imem_req), 32'(tbl[i].req));
            check($sformatf("t%0d_addr", i),  imem_addr,     tbl[i].addr);
            check($sformatf("t%0d_valid", i), 32'(valid_d),  32'(tbl[i].v));
            check($sformatf("t%0d_instr", i), instr_d,       tbl[i].nop ? NOP : mem_word(tbl[i].pc));
            if (tbl[i].v) begin
                check($sformatf("t%0d_pc", i),  pc_d,  tbl[i].pc);
                check($sformatf("t%0d_pc4", i), pc4_d, tbl[i].pc + 32'd4);
            end
            stall = tbl[i].stall;
            flush = tbl[i].flush;
            redir = tbl[i].redir;
        end
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;

        // 3-cycle latency: address held, IF/ID held and valid between handshakes
        mem_wait = 2;
        do_reset();
        wait_addr(32'h4, 20);
        for (int k = 0; k < 3; k++) begin
            check("lat_addr",   imem_addr,       32'h4);
            check("lat_req",    32'(imem_req),   32'd1);
            check("lat_mvalid", 32'(imem_valid), 32'(k == 2));
            check("lat_valid",  32'(valid_d),    32'd1);
            check("lat_pc",     pc_d,            32'h0);
            @(negedge clk);
        end
        check("lat_next_pc",   pc_d,      32'h4);
        check("lat_next_addr", imem_addr, 32'h8);

        // Two flushes while 0x10 is outstanding; stall is ignored while discarding
        wait_addr(32'h10, 40);
        flush = 1'b1;
        redir = 32'h200;
        @(negedge clk);
        check("dis1_addr",  imem_addr,     32'h10);
        check("dis1_valid", 32'(valid_d),  32'd0);
        check("dis1_instr", instr_d,       NOP);
        redir = 32'h300;
        @(negedge clk);
        check("dis2_addr",   imem_addr,       32'h10);
        check("dis2_mvalid", 32'(imem_valid), 32'd1);
        flush = 1'b0;
        stall = 1'b1;
        @(negedge clk);
        check("dis3_addr",  imem_addr,    32'h300);
        check("dis3_req",   32'(imem_req), 32'd1);
        check("dis3_valid", 32'(valid_d),  32'd0);
        stall = 1'b0;
        wait_valid_d(20);
        check("dis_first_pc",    pc_d,    32'h300);
        check("dis_first_instr", instr_d, mem_word(32'h300));

        // Asynchronous reset in the middle of DISCARD
        wait_addr(32'h308, 20);
        flush = 1'b1;
        redir = 32'h500;
        @(negedge clk);
        flush = 1'b0;
        check("ar_pre_addr", imem_addr, 32'h308);
        #2;
        rst = 1'b1;
        #1;
        check("ar_req",   32'(imem_req), 32'd0);
        check("ar_addr",  imem_addr,     32'h0);
        check("ar_instr", instr_d,       NOP);
        check("ar_pc",    pc_d,          32'h0);
        check("ar_pc4",   pc4_d,         32'h0);
        check("ar_valid", 32'(valid_d),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("ar_rel_req", 32'(imem_req), 32'd0);
        wait_addr(32'h0, 5);
        wait_valid_d(20);
        check("ar_first_pc", pc_d, 32'h0);

        // Randomized traffic against the transaction-level model
        mem_rand = 1'b1;
        do_reset();
        pend_q.delete();
        m_instr   = NOP;
        m_pc      = '0;
        m_pc4     = '0;
        m_v       = 1'b0;
        drop_next = 1'b0;
        exp_fetch = 32'h0;
        first     = 1'b1;
        prev_wait = 1'b0;
        prev_addr = '0;
        for (int it = 0; it < 2000; it++) begin
            check("rnd_valid", 32'(valid_d), 32'(m_v));
            check("rnd_instr", instr_d, m_instr);
            if (m_v) begin
                check("rnd_pc",  pc_d,  m_pc);
                check("rnd_pc4", pc4_d, m_pc4);
            end
            check("rnd_req", 32'(imem_req), 32'(!first && pend_q.size() == 0));
            if (prev_wait) check("rnd_addr_hold", imem_addr, prev_addr);

            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 11) == 0);
            redir = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
            #1;
            hs = imem_req && imem_valid;
            if (hs && !drop_next && !flush) check("rnd_fetch_addr", imem_addr, exp_fetch);
            prev_wait = imem_req && !imem_valid;
            prev_addr = imem_addr;

            if (flush) begin
                m_v       = 1'b0;
                m_instr   = NOP;
                pend_q.delete();
                drop_next = imem_req && !imem_valid;
                exp_fetch = redir;
            end else begin
                if (hs) begin
                    if (drop_next) begin
                        drop_next = 1'b0;
                    end else begin
                        pend_q.push_back(exp_fetch);
                        exp_fetch = exp_fetch + 32'd4;
                    end
                end
                if (!stall && pend_q.size() > 0) begin
                    p       = pend_q.pop_front();
                    m_pc    = p;
                    m_pc4   = p + 32'd4;
                    m_instr = mem_word(p);
                    m_v     = 1'b1;
                end
            end
            first = 1'b0;
            @(negedge clk);
        end
        stall = 1'b0;
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
